// File: rtl/adex_sched_pkg.sv
// Shared types and constants for the AdEx neuron scheduler.
package adex_sched_pkg;

    localparam int STATE_W = 16;
    localparam logic [STATE_W-1:0] V_INIT = 16'hBF00;  // -65.0 in Q8.8

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/adex_neuron_scheduler_if.sv
// Datapath req/ack handshake and spike-event stream of the AdEx scheduler.
interface adex_neuron_scheduler_if #(
    parameter int IDX_W   = 3,
    parameter int STATE_W = adex_sched_pkg::STATE_W
);
    logic               dp_req;
    logic [IDX_W-1:0]   dp_idx;
    logic [STATE_W-1:0] dp_v_o;
    logic [STATE_W-1:0] dp_w_o;
    logic               dp_ack;
    logic [STATE_W-1:0] dp_v_i;
    logic [STATE_W-1:0] dp_w_i;
    logic               dp_spike;
    logic               ev_valid;
    logic [IDX_W-1:0]   ev_idx;
    logic               ev_ready;

    modport master (
        output dp_req, dp_idx, dp_v_o, dp_w_o, ev_valid, ev_idx,
        input  dp_ack, dp_v_i, dp_w_i, dp_spike, ev_ready
    );

    modport slave (
        input  dp_req, dp_idx, dp_v_o, dp_w_o, ev_valid, ev_idx,
        output dp_ack, dp_v_i, dp_w_i, dp_spike, ev_ready
    );
endinterface

// File: rtl/adex_spike_fifo.sv
// Synchronous spike-event FIFO; empty/full told apart by a pointer wrap bit.
module adex_spike_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    import adex_sched_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_en;
    logic             push_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs
    assign push_en  = push && (!full || pop_en);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/adex_neuron_scheduler.sv
// Time-multiplexes one AdEx datapath over N_NEURONS virtual neurons per timestep tick.
module adex_neuron_scheduler #(
    parameter int N_NEURONS  = 8,
    parameter int IDX_W      = 3,
    parameter int STATE_W    = adex_sched_pkg::STATE_W,
    parameter int TICK_DIV   = 1000,
    parameter int FIFO_DEPTH = 4,
    parameter logic [STATE_W-1:0] V_INIT = adex_sched_pkg::V_INIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  init_req,
    input  logic                  clr_flags,
    adex_neuron_scheduler_if.master bus,
    output logic [N_NEURONS-1:0]  spike_vec,
    output logic                  busy,
    output logic                  overrun,
    output logic                  spike_drop
);
    import adex_sched_pkg::*;

    localparam int CNT_W = $clog2(TICK_DIV);

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [CNT_W-1:0]     tick_cnt;
    logic                 tick;
    logic [IDX_W-1:0]     idx;
    logic [N_NEURONS-1:0] acc;
    logic [STATE_W-1:0]   v_mem [N_NEURONS];
    logic [STATE_W-1:0]   w_mem [N_NEURONS];
    logic                 init_pend;
    logic                 do_init;
    logic                 start;
    logic                 ack_fire;
    logic                 last_idx;
    logic                 push;
    logic                 push_drop;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign tick     = enable && (tick_cnt == CNT_W'(TICK_DIV - 1));
    // Init (fresh or deferred) takes priority over a tick landing in IDLE
    assign do_init  = (state == IDLE) && (init_req || init_pend);
    assign start    = (state == IDLE) && tick && !do_init;
    assign ack_fire = (state == WAIT) && bus.dp_ack;
    assign last_idx = (idx == IDX_W'(N_NEURONS - 1));
    assign push     = ack_fire && bus.dp_spike;
    assign push_drop = push && fifo_full && !(bus.ev_ready && !fifo_empty);

    assign bus.dp_idx   = idx;
    assign bus.dp_v_o   = v_mem[idx];
    assign bus.dp_w_o   = w_mem[idx];
    assign bus.ev_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (enable) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (ack_fire) state_nxt = last_idx ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.dp_req = 1'b0;
        busy       = 1'b0;
        unique case (state)
            ISSUE, WAIT: begin
                bus.dp_req = 1'b1;
                busy       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            acc       <= '0;
            spike_vec <= '0;
            init_pend <= 1'b0;
        end else begin
            if (start) begin
                idx <= '0;
                acc <= '0;
            end
            if (ack_fire) begin
                acc[idx] <= bus.dp_spike;
                if (!last_idx) idx <= idx + 1'b1;
            end
            if (state == DONE) spike_vec <= acc;
            if (do_init)       spike_vec <= '0;
            if (do_init)       init_pend <= 1'b0;
            else if (init_req) init_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < unsigned'(N_NEURONS); i++) begin
                v_mem[i] <= V_INIT;
                w_mem[i] <= '0;
            end
        end else if (do_init) begin
            for (int unsigned i = 0; i < unsigned'(N_NEURONS); i++) begin
                v_mem[i] <= V_INIT;
                w_mem[i] <= '0;
            end
        end else if (ack_fire) begin
            v_mem[idx] <= bus.dp_v_i;
            w_mem[idx] <= bus.dp_w_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun    <= 1'b0;
            spike_drop <= 1'b0;
        end else begin
            if (tick && state != IDLE) overrun <= 1'b1;
            else if (clr_flags)        overrun <= 1'b0;
            if (push_drop)             spike_drop <= 1'b1;
            else if (clr_flags)        spike_drop <= 1'b0;
        end
    end

    adex_spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (idx),
        .pop       (bus.ev_ready),
        .pop_data  (bus.ev_idx),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_adex_neuron_scheduler.sv
// Self-checking bench: directed sweeps with randomized datapath results against a behavioural model.
module tb_adex_neuron_scheduler;

    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int SW   = 16;
    localparam int TDIV = 10;
    localparam int FD   = 2;
    localparam logic [15:0] VI = 16'hBF00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          init_req = 1'b0;
    logic          clr_flags = 1'b0;
    logic [N-1:0]  spike_vec;
    logic          busy;
    logic          overrun;
    logic          spike_drop;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [15:0]  m_v [N];
    logic [15:0]  m_w [N];
    logic [N-1:0] m_spk;
    int           q[$];
    bit           m_drop;
    bit           m_ovr;

    // per-sweep stimulus
    logic [15:0]  r_v [N];
    logic [15:0]  r_w [N];
    logic [N-1:0] r_spk;
    logic [N-1:0] r_pop;
    int           r_dly [N];
    int           r_init_at;

    adex_neuron_scheduler_if #(.IDX_W(IW), .STATE_W(SW)) bus ();

    adex_neuron_scheduler #(
        .N_NEURONS  (N),
        .IDX_W      (IW),
        .STATE_W    (SW),
        .TICK_DIV   (TDIV),
        .FIFO_DEPTH (FD),
        .V_INIT     (VI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .init_req   (init_req),
        .clr_flags  (clr_flags),
        .bus        (bus),
        .spike_vec  (spike_vec),
        .busy       (busy),
        .overrun    (overrun),
        .spike_drop (spike_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < N; i++) begin
            m_v[i] = VI;
            m_w[i] = '0;
        end
        m_spk = '0;
    endtask

    task automatic model_reset();
        model_init();
        q.delete();
        m_drop = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic rand_sweep();
        for (int i = 0; i < N; i++) begin
            r_v[i]   = 16'($urandom);
            r_w[i]   = 16'($urandom);
            r_dly[i] = int'($urandom_range(3, 1));
        end
        r_spk     = 4'($urandom);
        r_pop     = 4'($urandom);
        r_init_at = -1;
    endtask

    task automatic check_status();
        chk("spike_vec", 32'(spike_vec), 32'(m_spk));
        chk("ev_valid", 32'(bus.ev_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("ev_idx_head", 32'(bus.ev_idx), 32'(q[0]));
        chk("spike_drop", 32'(spike_drop), 32'(m_drop));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    // lat > 0: exact number of cycles from now until dp_req is expected
    task automatic run_sweep(input int lat, input bit keep_en);
        logic [N-1:0] acc;
        bit           do_init;
        int           sz;
        bit           popping;
        int           n;
        acc     = '0;
        do_init = 1'b0;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dp_req && n < 40);
        chk("sweep_start", 32'(bus.dp_req), 32'd1);
        if (lat > 0) chk("tick_latency", 32'(n), 32'(lat));
        if (!keep_en) enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("req_high", 32'(bus.dp_req), 32'd1);
            chk("busy_high", 32'(busy), 32'd1);
            chk("dp_idx", 32'(bus.dp_idx), 32'(i));
            chk("dp_v_o", 32'(bus.dp_v_o), 32'(m_v[i]));
            chk("dp_w_o", 32'(bus.dp_w_o), 32'(m_w[i]));
            repeat (r_dly[i]) @(negedge clk);
            chk("req_held", 32'(bus.dp_req), 32'd1);
            chk("idx_held", 32'(bus.dp_idx), 32'(i));
            bus.dp_ack   = 1'b1;
            bus.dp_v_i   = r_v[i];
            bus.dp_w_i   = r_w[i];
            bus.dp_spike = r_spk[i];
            bus.ev_ready = r_pop[i];
            init_req     = (r_init_at == i);
            enable       = 1'b0;
            if (r_init_at == i) do_init = 1'b1;
            sz      = q.size();
            popping = r_pop[i] && (sz > 0);
            if (popping) begin
                chk("ev_idx_pop", 32'(bus.ev_idx), 32'(q[0]));
                void'(q.pop_front());
            end
            if (r_spk[i]) begin
                if (sz < FD || popping) q.push_back(i);
                else m_drop = 1'b1;
            end
            m_v[i] = r_v[i];
            m_w[i] = r_w[i];
            acc[i] = r_spk[i];
            @(negedge clk);
            bus.dp_ack   = 1'b0;
            bus.ev_ready = 1'b0;
            init_req     = 1'b0;
        end
        chk("busy_after_last_ack", 32'(busy), 32'd0);
        chk("req_after_last_ack", 32'(bus.dp_req), 32'd0);
        repeat (2) @(negedge clk);
        m_spk = acc;
        if (do_init) model_init();
        check_status();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 2 * FD) begin
            chk("drain_valid", 32'(bus.ev_valid), 32'd1);
            chk("drain_idx", 32'(bus.ev_idx), 32'(q[0]));
            bus.ev_ready = 1'b1;
            void'(q.pop_front());
            @(negedge clk);
            n++;
        end
        bus.ev_ready = 1'b0;
        chk("drain_empty", 32'(bus.ev_valid), 32'd0);
    endtask

    initial begin
        bus.dp_ack   = 1'b0;
        bus.dp_v_i   = '0;
        bus.dp_w_i   = '0;
        bus.dp_spike = 1'b0;
        bus.ev_ready = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_dp_req", 32'(bus.dp_req), 32'd0);
        chk("rst_dp_idx", 32'(bus.dp_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ev_valid", 32'(bus.ev_valid), 32'd0);
        chk("rst_spike_vec", 32'(spike_vec), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_spike_drop", 32'(spike_drop), 32'd0);
        chk("rst_v", 32'(bus.dp_v_o), 32'(VI));
        chk("rst_w", 32'(bus.dp_w_o), 32'd0);

        // first sweep: V = idx*256, spikes on 1 and 3
        rst_n  = 1'b1;
        enable = 1'b1;
        rand_sweep();
        for (int i = 0; i < N; i++) begin
            r_v[i]   = 16'(i * 256);
            r_dly[i] = 2;
        end
        r_spk = 4'b1010;
        r_pop = '0;
        run_sweep(TDIV, 1'b0);

        // FIFO already full with {1,3}: any spike is dropped
        enable = 1'b1;
        rand_sweep();
        r_spk = r_spk | 4'b0001;
        r_pop = '0;
        run_sweep(TDIV, 1'b0);
        drain();

        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        m_drop    = 1'b0;
        chk("clr_spike_drop", 32'(spike_drop), 32'd0);

        // fills FIFO, then push with simultaneous pop while full
        enable = 1'b1;
        rand_sweep();
        r_spk = 4'b1011;
        r_pop = 4'b1000;
        run_sweep(TDIV, 1'b0);
        drain();

        for (int k = 0; k < 4; k++) begin
            enable = 1'b1;
            rand_sweep();
            run_sweep(TDIV, 1'b0);
        end

        // init coinciding with a tick in IDLE
        enable = 1'b1;
        repeat (9) @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        enable   = 1'b0;
        model_init();
        chk("init_tick_no_req", 32'(bus.dp_req), 32'd0);
        chk("init_tick_no_overrun", 32'(overrun), 32'(m_ovr));
        chk("init_tick_spike_vec", 32'(spike_vec), 32'd0);

        enable = 1'b1;
        rand_sweep();
        r_spk = r_spk | 4'b0100;
        run_sweep(TDIV, 1'b0);

        // init requested mid-sweep is applied after DONE
        enable = 1'b1;
        rand_sweep();
        r_spk     = r_spk | 4'b1000;
        r_init_at = 1;
        run_sweep(TDIV, 1'b0);

        enable = 1'b1;
        rand_sweep();
        run_sweep(TDIV, 1'b0);

        // long ack on neuron 0 spans the next tick
        enable = 1'b1;
        rand_sweep();
        r_dly[0] = 12;
        m_ovr    = 1'b1;
        run_sweep(TDIV, 1'b1);
        repeat (12) @(negedge clk);
        chk("dropped_tick_not_run", 32'(bus.dp_req), 32'd0);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        m_ovr     = 1'b0;
        chk("clr_overrun", 32'(overrun), 32'd0);

        // asynchronous reset while waiting for an ack
        enable = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.dp_req && n < 40);
            chk("pre_reset_req", 32'(bus.dp_req), 32'd1);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(bus.dp_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_idx", 32'(bus.dp_idx), 32'd0);
        chk("async_rst_v", 32'(bus.dp_v_o), 32'(VI));
        chk("async_rst_ev_valid", 32'(bus.ev_valid), 32'd0);
        chk("async_rst_spike_vec", 32'(spike_vec), 32'd0);
        chk("async_rst_flags", 32'({overrun, spike_drop}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        rand_sweep();
        run_sweep(TDIV, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
